// File: rtl/alu_mc_pkg.sv
// Purpose: shared opcodes, FSM states and mul/div step modes for the multi-cycle ALU.
// Latency: n/a (definitions only).
// Backpressure: n/a.
// Ports: none.
package alu_mc_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_ORR  = 4'd3;
  localparam logic [3:0] OP_NOT  = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_LSR  = 4'd6;
  localparam logic [3:0] OP_LSL  = 4'd7;
  localparam logic [3:0] OP_ADC  = 4'd8;
  localparam logic [3:0] OP_SBC  = 4'd9;
  localparam logic [3:0] OP_ASR  = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;
  localparam logic [3:0] OP_DIV  = 4'd12;
  localparam logic [3:0] OP_REM  = 4'd13;
  localparam logic [3:0] OP_CMP  = 4'd14;
  localparam logic [3:0] OP_PASS = 4'd15;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  // Step mode for the iterative unit; MD_IDLE freezes its registers.
  localparam logic [1:0] MD_IDLE = 2'd0;
  localparam logic [1:0] MD_MUL  = 2'd1;
  localparam logic [1:0] MD_DIV  = 2'd2;

  function automatic logic is_iter_op(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/alu_mc_muldiv.sv
// Purpose: iterative unsigned shift-add multiplier and restoring divider (one step per cycle).
// Latency: WIDTH steps after load; results valid once the owner stops stepping.
// Backpressure: none; owner controls stepping via mode (MD_IDLE holds state).
// Ports: clk, rst, load (latch a/b, clear accumulators), mode[1:0] (step kind),
//        a, b operands; lo/hi = product halves, quo/rem = quotient/remainder, dz = b==0.
module alu_muldiv
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem,
  output logic             dz
);

  logic [WIDTH-1:0] b_q, p_hi, p_lo, r_q, q_q;
  logic [WIDTH:0]   add_sum, shifted;
  logic [WIDTH-1:0] diff;

  always_comb begin
    // Multiplier: low half holds the remaining multiplier bits, consumed LSB first.
    add_sum = {1'b0, p_hi} + (p_lo[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
    // Divider: bring the next dividend bit into the partial remainder.
    shifted = {r_q, q_q[WIDTH-1]};
    // Only used when shifted >= b, where the true difference fits in WIDTH bits.
    diff    = shifted[WIDTH-1:0] - b_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_q  <= '0;
      p_hi <= '0;
      p_lo <= '0;
      r_q  <= '0;
      q_q  <= '0;
    end else if (load) begin
      b_q  <= b;
      p_hi <= '0;
      p_lo <= a;
      r_q  <= '0;
      q_q  <= a;
    end else if (mode == MD_MUL) begin
      {p_hi, p_lo} <= {add_sum, p_lo[WIDTH-1:1]};
    end else if (mode == MD_DIV) begin
      // With b==0 every trial subtract succeeds: quotient all ones, remainder = a.
      if (shifted >= {1'b0, b_q}) begin
        r_q <= diff;
        q_q <= {q_q[WIDTH-2:0], 1'b1};
      end else begin
        r_q <= shifted[WIDTH-1:0];
        q_q <= {q_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign lo  = p_lo;
  assign hi  = p_hi;
  assign quo = q_q;
  assign rem = r_q;
  assign dz  = (b_q == '0);

endmodule

// File: rtl/alu_mc.sv
// Purpose: multi-cycle ALU with registered result and N/Z/C/V/P flags.
// Latency: 1 cycle for single-cycle ops; WIDTH+1 cycles for MUL/DIV/REM.
// Backpressure: busy high during iteration; start is ignored unless the FSM is idle.
// Ports: clk, rst (async, active-high), start/op/rs/rt/cin request;
//        busy, done (1-cycle pulse), rd and fN/fZ/fC/fV/fP held until the next done.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rd,
  output logic             fN,
  output logic             fZ,
  output logic             fC,
  output logic             fV,
  output logic             fP
);

  localparam int M = WIDTH - 1;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       op_q;

  logic [WIDTH:0]   wide;
  logic [WIDTH-1:0] sc_val, fin_val;
  logic             sc_c, sc_v, sc_wr, fin_c, fin_v;

  logic             md_load;
  logic [1:0]       md_mode;
  logic [WIDTH-1:0] md_lo, md_hi, md_quo, md_rem;
  logic             md_dz;

  // Single-cycle datapath. sc_val also carries the CMP difference, which sets
  // flags but is not written to rd.
  always_comb begin
    wide   = '0;
    sc_val = '0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    sc_wr  = 1'b1;
    case (op)
      OP_ADD, OP_ADC: begin
        wide   = {1'b0, rs} + {1'b0, rt} + {{WIDTH{1'b0}}, (op == OP_ADC) & cin};
        sc_val = wide[M:0];
        sc_c   = wide[WIDTH];
        sc_v   = (rs[M] == rt[M]) && (sc_val[M] != rs[M]);
      end
      OP_SUB, OP_SBC, OP_CMP: begin
        // Top bit of the widened difference is the borrow.
        wide   = {1'b0, rs} - {1'b0, rt} - {{WIDTH{1'b0}}, (op == OP_SBC) & cin};
        sc_val = wide[M:0];
        sc_c   = wide[WIDTH];
        sc_v   = (rs[M] != rt[M]) && (sc_val[M] != rs[M]);
        sc_wr  = (op != OP_CMP);
      end
      OP_AND:  sc_val = rs & rt;
      OP_ORR:  sc_val = rs | rt;
      OP_XOR:  sc_val = rs ^ rt;
      OP_NOT:  sc_val = ~rs;
      OP_PASS: sc_val = rs;
      OP_LSR: begin
        sc_val = {1'b0, rs[M:1]};
        sc_c   = rs[0];
      end
      OP_LSL: begin
        sc_val = {rs[M-1:0], 1'b0};
        sc_c   = rs[M];
      end
      OP_ASR: begin
        sc_val = {rs[M], rs[M:1]};
        sc_c   = rs[0];
      end
      default: sc_wr = 1'b0;
    endcase
  end

  // Result selection once the iterative unit has finished.
  always_comb begin
    fin_c = 1'b0;
    fin_v = md_dz;
    case (op_q)
      OP_MUL: begin
        fin_val = md_lo;
        fin_c   = |md_hi;
        fin_v   = |md_hi;
      end
      OP_DIV:  fin_val = md_quo;
      default: fin_val = md_rem;
    endcase
  end

  assign md_load = (state == S_IDLE) && start && is_iter_op(op);
  assign md_mode = (state != S_ITER) ? MD_IDLE : ((op_q == OP_MUL) ? MD_MUL : MD_DIV);

  alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk  (clk),
    .rst  (rst),
    .load (md_load),
    .mode (md_mode),
    .a    (rs),
    .b    (rt),
    .lo   (md_lo),
    .hi   (md_hi),
    .quo  (md_quo),
    .rem  (md_rem),
    .dz   (md_dz)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      op_q  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      rd    <= '0;
      fN    <= 1'b0;
      fZ    <= 1'b0;
      fC    <= 1'b0;
      fV    <= 1'b0;
      fP    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (is_iter_op(op)) begin
              state <= S_ITER;
              cnt   <= CNT_W'(WIDTH);
              op_q  <= op;
              busy  <= 1'b1;
            end else begin
              if (sc_wr) rd <= sc_val;
              fN   <= sc_val[M];
              fZ   <= (sc_val == '0);
              fP   <= ~sc_val[0];
              fC   <= sc_c;
              fV   <= sc_v;
              done <= 1'b1;
            end
          end
        end
        S_ITER: begin
          cnt <= cnt - 1'b1;
          // This edge performs the last step; busy drops for the FIN cycle.
          if (cnt == CNT_W'(1)) begin
            state <= S_FIN;
            busy  <= 1'b0;
          end
        end
        S_FIN: begin
          rd    <= fin_val;
          fN    <= fin_val[M];
          fZ    <= (fin_val == '0);
          fP    <= ~fin_val[0];
          fC    <= fin_c;
          fV    <= fin_v;
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Purpose: self-checking bench for alu_mc (WIDTH=16) against a behavioural model.
// Latency: n/a.
// Backpressure: n/a.
module tb_alu_mc;
  import alu_mc_pkg::*;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [3:0]   op;
  logic [W-1:0] rs, rt;
  logic         cin;
  logic         busy, done, fN, fZ, fC, fV, fP;
  logic [W-1:0] rd;

  alu_mc #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rs(rs), .rt(rt), .cin(cin),
    .busy(busy), .done(done), .rd(rd), .fN(fN), .fZ(fZ), .fC(fC), .fV(fV), .fP(fP)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [W-1:0] rd;
    logic n, z, c, v, p;
  } res_t;

  int     cyc = 0;
  int     blk_until, pend_at, busy_from, busy_to;
  res_t   pend, m;
  logic   m_done, m_busy;

  function automatic logic ovf(input int x);
    return (x > 32767) || (x < -32768);
  endfunction

  function automatic res_t model_op(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic ci, input logic [W-1:0] cur);
    res_t r;
    int s;
    longint prod;
    logic [W-1:0] val;
    logic wr;
    r = '0; val = '0; wr = 1'b1; s = 0; prod = 0;
    case (o)
      OP_ADD, OP_ADC: begin
        s = int'(a) + int'(b) + ((o == OP_ADC) ? int'(ci) : 0);
        val = s[W-1:0];
        r.c = (s > 65535);
        r.v = ovf(int'($signed(a)) + int'($signed(b)) + ((o == OP_ADC) ? int'(ci) : 0));
      end
      OP_SUB, OP_SBC, OP_CMP: begin
        s = int'(a) - int'(b) - ((o == OP_SBC) ? int'(ci) : 0);
        val = s[W-1:0];
        r.c = (s < 0);
        r.v = ovf(int'($signed(a)) - int'($signed(b)) - ((o == OP_SBC) ? int'(ci) : 0));
        wr = (o != OP_CMP);
      end
      OP_AND:  val = a & b;
      OP_ORR:  val = a | b;
      OP_XOR:  val = a ^ b;
      OP_NOT:  val = ~a;
      OP_PASS: val = a;
      OP_LSR: begin val = a >> 1; r.c = a[0]; end
      OP_LSL: begin val = a << 1; r.c = a[W-1]; end
      OP_ASR: begin val = W'($signed(a) >>> 1); r.c = a[0]; end
      OP_MUL: begin
        prod = longint'(a) * longint'(b);
        val = prod[W-1:0];
        r.c = (prod >= 65536);
        r.v = r.c;
      end
      OP_DIV: begin
        if (b == 0) begin val = 16'hFFFF; r.v = 1'b1; end
        else val = a / b;
      end
      default: begin // OP_REM
        if (b == 0) begin val = a; r.v = 1'b1; end
        else val = a % b;
      end
    endcase
    r.n = val[W-1];
    r.z = (val == 0);
    r.p = ~val[0];
    r.rd = wr ? val : cur;
    return r;
  endfunction

  task automatic model_reset();
    m = '0; m_done = 1'b0; m_busy = 1'b0;
    blk_until = -1; pend_at = -1; busy_from = 0; busy_to = -1;
  endtask

  // Called just after a rising edge, with the inputs the DUT sampled at that edge.
  task automatic model_edge();
    m_done = 1'b0;
    if (pend_at == cyc) begin
      m = pend;
      m_done = 1'b1;
    end
    if (start && cyc > blk_until) begin
      if (op == OP_MUL || op == OP_DIV || op == OP_REM) begin
        pend      = model_op(op, rs, rt, cin, m.rd);
        pend_at   = cyc + W + 1;
        blk_until = cyc + W + 1;
        busy_from = cyc;
        busy_to   = cyc + W - 1;
      end else begin
        m = model_op(op, rs, rt, cin, m.rd);
        m_done = 1'b1;
        blk_until = cyc;
      end
    end
    m_busy = (cyc >= busy_from) && (cyc <= busy_to);
  endtask

  task automatic compare();
    chk($sformatf("cycle%0d {busy,done,rd,N,Z,C,V,P}", cyc),
        {busy, done, rd, fN, fZ, fC, fV, fP},
        {m_busy, m_done, m.rd, m.n, m.z, m.c, m.v, m.p});
  endtask

  // Drive one cycle of inputs (from a falling edge), update model at the rising
  // edge, compare at the next falling edge.
  task automatic step(input logic s, input logic [3:0] o, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic ci);
    start = s; op = o; rs = a; rt = b; cin = ci;
    @(posedge clk);
    cyc++;
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic idle();
    step(1'b0, 4'($urandom), W'($urandom), W'($urandom), 1'($urandom));
  endtask

  task automatic run_iter(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output int bcnt);
    lat = -1; bcnt = 0;
    step(1'b1, o, a, b, 1'b0);
    if (busy) bcnt++;
    for (int i = 1; i <= 40 && lat < 0; i++) begin
      idle();
      if (busy) bcnt++;
      if (done) lat = i;
    end
  endtask

  function automatic logic [31:0] outv();
    return {10'd0, done, rd, fN, fZ, fC, fV, fP};
  endfunction

  function automatic logic [31:0] expv(input logic d, input logic [W-1:0] r, input logic n,
                                       input logic z, input logic c, input logic v, input logic p);
    return {10'd0, d, r, n, z, c, v, p};
  endfunction

  int lat, bc, ndone;
  logic got;
  logic [W-1:0] a_r, b_r;

  initial begin
    rst = 1'b1; start = 1'b0; op = '0; rs = '0; rt = '0; cin = 1'b0;
    model_reset();
    @(negedge clk); @(negedge clk);
    chk("reset_state", {busy, outv()}, {1'b0, expv(0, 16'h0000, 0, 0, 0, 0, 0)});
    rst = 1'b0;
    idle();

    // ADD wrap to zero
    step(1'b1, OP_ADD, 16'hFFFF, 16'h0001, 1'b0);
    chk("add_ffff_1", outv(), expv(1, 16'h0000, 0, 1, 1, 0, 1));
    idle();
    chk("done_one_cycle", {31'd0, done}, 32'd0);

    // SUB overflow, then CMP keeps rd
    step(1'b1, OP_SUB, 16'h8000, 16'h0001, 1'b0);
    chk("sub_8000_1", outv(), expv(1, 16'h7FFF, 0, 0, 0, 1, 0));
    step(1'b1, OP_CMP, 16'h0003, 16'h0005, 1'b0);
    chk("cmp_3_5", outv(), expv(1, 16'h7FFF, 1, 0, 1, 0, 1));

    // MUL latency, busy width and results
    run_iter(OP_MUL, 16'h0100, 16'h0100, lat, bc);
    chk("mul_latency", 32'(lat), 32'd17);
    chk("mul_busy_cycles", 32'(bc), 32'd16);
    chk("mul_100_100", outv(), expv(1, 16'h0000, 0, 1, 1, 1, 1));
    run_iter(OP_MUL, 16'h00FF, 16'h0003, lat, bc);
    chk("mul_ff_3", outv(), expv(1, 16'h02FD, 0, 0, 0, 0, 0));

    // Divide cases
    run_iter(OP_DIV, 16'd100, 16'd7, lat, bc);
    chk("div_lat", 32'(lat), 32'd17);
    chk("div_100_7", outv(), expv(1, 16'd14, 0, 0, 0, 0, 1));
    run_iter(OP_REM, 16'd100, 16'd7, lat, bc);
    chk("rem_lat", 32'(lat), 32'd17);
    chk("rem_100_7", outv(), expv(1, 16'd2, 0, 0, 0, 0, 1));
    run_iter(OP_DIV, 16'h1234, 16'h0000, lat, bc);
    chk("divz_lat", 32'(lat), 32'd17);
    chk("div_by_zero", outv(), expv(1, 16'hFFFF, 1, 0, 0, 1, 0));
    run_iter(OP_REM, 16'h1234, 16'h0000, lat, bc);
    chk("remz_lat", 32'(lat), 32'd17);
    chk("rem_by_zero", outv(), expv(1, 16'h1234, 0, 0, 0, 1, 1));

    // Start during busy is ignored
    step(1'b1, OP_DIV, 16'd1000, 16'd10, 1'b0);
    idle(); idle(); idle();
    step(1'b1, OP_ADD, 16'd5, 16'd5, 1'b0);
    ndone = 0;
    for (int i = 0; i < 30; i++) begin
      idle();
      if (done) begin
        ndone++;
        chk("busy_ignore_rd", 32'(rd), 32'd100);
      end
    end
    chk("busy_ignore_ndone", 32'(ndone), 32'd1);

    // Start in the done cycle is accepted
    step(1'b1, OP_REM, 16'd100, 16'd7, 1'b0);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      idle();
      got = done;
    end
    chk("b2b_first_done", 32'(got), 32'd1);
    step(1'b1, OP_ADD, 16'd1, 16'd2, 1'b0);
    chk("b2b_add", outv(), expv(1, 16'd3, 0, 0, 0, 0, 0));

    // Async reset mid-MUL
    step(1'b1, OP_MUL, 16'h1234, 16'h5678, 1'b0);
    for (int i = 0; i < 4; i++) idle();
    #2 rst = 1'b1;
    #1 chk("async_reset", {busy, outv()}, {1'b0, expv(0, 16'h0000, 0, 0, 0, 0, 0)});
    model_reset();
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 30; i++) begin
      idle();
      if (done) ndone++;
    end
    chk("no_done_after_reset", 32'(ndone), 32'd0);

    // ADC overflow and ASR
    step(1'b1, OP_ADC, 16'h7FFF, 16'h0000, 1'b1);
    chk("adc_7fff_0_1", outv(), expv(1, 16'h8000, 1, 0, 0, 1, 1));
    step(1'b1, OP_ASR, 16'h8001, 16'h0000, 1'b0);
    chk("asr_8001", outv(), expv(1, 16'hC000, 1, 0, 1, 0, 1));

    // Randomised traffic with per-cycle model comparison
    for (int i = 0; i < 3000; i++) begin
      a_r = ($urandom_range(0, 7) == 0) ? 16'hFFFF : W'($urandom);
      b_r = ($urandom_range(0, 5) == 0) ? 16'h0000 : W'($urandom);
      if ($urandom_range(0, 3) == 0) b_r = W'($urandom_range(1, 20));
      step(1'($urandom_range(0, 2) == 0), 4'($urandom), a_r, b_r, 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
